// File: rtl/crono_pkg.sv
// Shared types and BCD helpers for the multi-channel countdown timer.
package crono_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG,
    ST_RUN,
    ST_PAUSE,
    ST_RING
  } chan_state_e;

  typedef enum logic [1:0] {
    CUR_SEC,
    CUR_MIN,
    CUR_HOUR
  } cursor_e;

  localparam logic [7:0] BCD_59 = 8'h59;
  localparam logic [7:0] BCD_00 = 8'h00;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;

  function automatic logic [7:0] to_bcd(input int unsigned n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Wraps to 00 past max; max is itself a BCD value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v >= max) return BCD_00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == BCD_00) return max;
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    return v - 8'h01;
  endfunction

  // One-second decrement with borrow across fields; callers never pass zero.
  function automatic bcd_time_t time_dec(input bcd_time_t t, input logic [7:0] hmax);
    bcd_time_t r;
    r = t;
    if (t.ss != BCD_00) begin
      r.ss = bcd_dec(t.ss, BCD_59);
    end else begin
      r.ss = BCD_59;
      if (t.mm != BCD_00) begin
        r.mm = bcd_dec(t.mm, BCD_59);
      end else begin
        r.mm = BCD_59;
        r.hh = bcd_dec(t.hh, hmax);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/crono_canal.sv
// One countdown channel: mode FSM, BCD time value/preset and ring-duration counter.
module crono_canal
  import crono_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int RING_SEC = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        i_tick,
  input  logic        i_prog_enter,
  input  logic        i_prog_exit,
  input  logic        i_push,
  input  logic        i_up,
  input  logic        i_down,
  input  logic        i_left,
  input  logic        i_right,
  output bcd_time_t   o_value,
  output chan_state_e o_state,
  output logic        o_run,
  output logic        o_ring,
  output logic        o_fin
);

  localparam logic [7:0] HOUR_MAX_BCD = to_bcd(HOUR_MAX);
  localparam int         RC_W         = $clog2(RING_SEC + 1);

  chan_state_e      r_state;
  bcd_time_t        r_value;
  bcd_time_t        r_preset;
  cursor_e          r_cursor;
  logic [RC_W-1:0]  r_ring_cnt;
  logic             r_run;
  logic             r_ring;
  logic             r_fin;

  bcd_time_t  w_dec;
  logic [7:0] w_field;
  logic [7:0] w_field_max;
  logic [7:0] w_field_new;
  cursor_e    w_cursor_new;

  assign w_dec = time_dec(r_value, HOUR_MAX_BCD);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_field     = r_value.ss;
    w_field_max = BCD_59;
    case (r_cursor)
      CUR_MIN:  w_field = r_value.mm;
      CUR_HOUR: begin
        w_field     = r_value.hh;
        w_field_max = HOUR_MAX_BCD;
      end
      default: ;
    endcase
    w_field_new = i_up ? bcd_inc(w_field, w_field_max) : bcd_dec(w_field, w_field_max);

    w_cursor_new = r_cursor;
    if (i_left && !i_right) begin
      case (r_cursor)
        CUR_SEC: w_cursor_new = CUR_MIN;
        CUR_MIN: w_cursor_new = CUR_HOUR;
        default: w_cursor_new = CUR_SEC;
      endcase
    end else if (i_right && !i_left) begin
      case (r_cursor)
        CUR_SEC:  w_cursor_new = CUR_HOUR;
        CUR_HOUR: w_cursor_new = CUR_MIN;
        default:  w_cursor_new = CUR_SEC;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_value    <= TIME_ZERO;
      r_preset   <= TIME_ZERO;
      r_cursor   <= CUR_SEC;
      r_ring_cnt <= '0;
      r_run      <= 1'b0;
      r_ring     <= 1'b0;
      r_fin      <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_state)
        ST_IDLE, ST_PAUSE: begin
          if (i_prog_enter) begin
            r_state  <= ST_PROG;
            r_cursor <= CUR_SEC;
          end else if (i_push && r_value != TIME_ZERO) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end
        end
        ST_PROG: begin
          if (i_prog_exit) begin
            r_state  <= ST_IDLE;
            r_preset <= r_value;
          end else begin
            if (i_up ^ i_down) begin
              case (r_cursor)
                CUR_MIN:  r_value.mm <= w_field_new;
                CUR_HOUR: r_value.hh <= w_field_new;
                default:  r_value.ss <= w_field_new;
              endcase
            end
            r_cursor <= w_cursor_new;
          end
        end
        ST_RUN: begin
          if (i_push) begin
            r_state <= ST_PAUSE;
            r_run   <= 1'b0;
          end else if (i_tick) begin
            r_value <= w_dec;
            if (w_dec == TIME_ZERO) begin
              r_state    <= ST_RING;
              r_run      <= 1'b0;
              r_ring     <= 1'b1;
              r_fin      <= 1'b1;
              r_ring_cnt <= '0;
            end
          end
        end
        ST_RING: begin
          if (i_push || (i_tick && r_ring_cnt == RC_W'(RING_SEC - 1))) begin
            r_state    <= ST_IDLE;
            r_ring     <= 1'b0;
            r_value    <= r_preset;
            r_ring_cnt <= '0;
          end else if (i_tick) begin
            r_ring_cnt <= r_ring_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_value = r_value;
  assign o_state = r_state;
  assign o_run   = r_run;
  assign o_ring  = r_ring;
  assign o_fin   = r_fin;

endmodule

// File: rtl/crono_multicanal.sv
// Multi-channel countdown timer: button edge detection, programming lock, routing and display mux.
module crono_multicanal
  import crono_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int HOUR_MAX = 23,
  parameter int RING_SEC = 10
) (
  input  logic                                   clk,
  input  logic                                   Reset,
  input  logic                                   tick_1s,
  input  logic                                   ProgramarCrono,
  input  logic                                   PushInicioCrono,
  input  logic                                   arriba,
  input  logic                                   abajo,
  input  logic                                   izquierda,
  input  logic                                   derecha,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] canal_sel,
  output logic [7:0]                             horasSal,
  output logic [7:0]                             minutosSal,
  output logic [7:0]                             segundosSal,
  output logic [N_CH-1:0]                        CronoActivo,
  output logic [N_CH-1:0]                        Ring,
  output logic [N_CH-1:0]                        FinalizoCrono
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [4:0]      r_btn_prev;
  logic            r_lock;
  logic [CH_W-1:0] r_lock_ch;
  bcd_time_t       r_disp;

  logic [4:0]  w_btn;
  logic [4:0]  w_edge;
  chan_state_e w_state [N_CH];
  bcd_time_t   w_value [N_CH];
  chan_state_e w_sel_state;
  bcd_time_t   w_sel_value;
  logic        w_enter;

  assign w_btn  = {PushInicioCrono, arriba, abajo, izquierda, derecha};
  assign w_edge = w_btn & ~r_btn_prev;

  // Out-of-range selects read as RUN so they can never be locked for programming.
  always_comb begin
    w_sel_state = ST_RUN;
    w_sel_value = TIME_ZERO;
    for (int i = 0; i < N_CH; i++) begin
      if (canal_sel == CH_W'(i)) begin
        w_sel_state = w_state[i];
        w_sel_value = w_value[i];
      end
    end
  end

  assign w_enter = ProgramarCrono && !r_lock &&
                   (w_sel_state == ST_IDLE || w_sel_state == ST_PAUSE);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_btn_prev <= '0;
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
      r_disp     <= TIME_ZERO;
    end else begin
      r_btn_prev <= w_btn;
      r_lock     <= ProgramarCrono && (r_lock || w_enter);
      if (w_enter) r_lock_ch <= canal_sel;
      r_disp     <= w_sel_value;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic w_is_sel;
    logic w_is_lock;
    assign w_is_sel  = (canal_sel == CH_W'(i));
    assign w_is_lock = r_lock && (r_lock_ch == CH_W'(i));

    crono_canal #(
      .HOUR_MAX (HOUR_MAX),
      .RING_SEC (RING_SEC)
    ) u_canal (
      .clk          (clk),
      .Reset        (Reset),
      .i_tick       (tick_1s),
      .i_prog_enter (w_enter && w_is_sel),
      .i_prog_exit  (w_is_lock && !ProgramarCrono),
      .i_push       (w_edge[4] && !ProgramarCrono && w_is_sel),
      .i_up         (w_edge[3] && w_is_lock),
      .i_down       (w_edge[2] && w_is_lock),
      .i_left       (w_edge[1] && w_is_lock),
      .i_right      (w_edge[0] && w_is_lock),
      .o_value      (w_value[i]),
      .o_state      (w_state[i]),
      .o_run        (CronoActivo[i]),
      .o_ring       (Ring[i]),
      .o_fin        (FinalizoCrono[i])
    );
  end

  assign horasSal    = r_disp.hh;
  assign minutosSal  = r_disp.mm;
  assign segundosSal = r_disp.ss;

endmodule

// File: tb/tb_crono_multicanal.sv
// Scenario and randomized checks of crono_multicanal against a seconds-based reference model.
module tb_crono_multicanal;

  localparam int N_CH     = 2;
  localparam int HOUR_MAX = 23;
  localparam int RING_SEC = 10;

  localparam int S_IDLE  = 0;
  localparam int S_PROG  = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_RING  = 4;

  logic clk = 1'b0;
  logic rst, tick, prog, push, up, dn, lf, rt;
  logic [0:0] sel;
  logic [7:0] hh_o, mm_o, ss_o;
  logic [N_CH-1:0] act_o, ring_o, fin_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  crono_multicanal #(
    .N_CH     (N_CH),
    .HOUR_MAX (HOUR_MAX),
    .RING_SEC (RING_SEC)
  ) dut (
    .clk             (clk),
    .Reset           (rst),
    .tick_1s         (tick),
    .ProgramarCrono  (prog),
    .PushInicioCrono (push),
    .arriba          (up),
    .abajo           (dn),
    .izquierda       (lf),
    .derecha         (rt),
    .canal_sel       (sel),
    .horasSal        (hh_o),
    .minutosSal      (mm_o),
    .segundosSal     (ss_o),
    .CronoActivo     (act_o),
    .Ring            (ring_o),
    .FinalizoCrono   (fin_o)
  );

  // Reference model: per-channel mode, time as plain integers, preset, cursor (0 s, 1 m, 2 h).
  int m_st [N_CH];
  int m_h [N_CH], m_m [N_CH], m_s [N_CH];
  int p_h [N_CH], p_m [N_CH], p_s [N_CH];
  int m_cur [N_CH];
  int m_ticks_in_ring [N_CH];
  bit m_lock;
  int m_lock_ch;
  bit q_push, q_up, q_dn, q_lf, q_rt;
  logic [N_CH-1:0] e_act, e_ring, e_fin;
  int e_h, e_m, e_s;

  function automatic logic [7:0] bcd(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  task automatic model_step();
    bit ep, eu, ed, el, er, enter, leave, mine;
    int s, t, f;
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        m_st[c] = S_IDLE; m_h[c] = 0; m_m[c] = 0; m_s[c] = 0;
        p_h[c] = 0; p_m[c] = 0; p_s[c] = 0; m_cur[c] = 0; m_ticks_in_ring[c] = 0;
      end
      m_lock = 0; m_lock_ch = 0;
      {q_push, q_up, q_dn, q_lf, q_rt} = '0;
      e_act = '0; e_ring = '0; e_fin = '0; e_h = 0; e_m = 0; e_s = 0;
      return;
    end
    s  = int'(sel);
    ep = push && !q_push; eu = up && !q_up; ed = dn && !q_dn;
    el = lf && !q_lf;     er = rt && !q_rt;
    e_h = m_h[s]; e_m = m_m[s]; e_s = m_s[s];
    enter = prog && !m_lock && (m_st[s] == S_IDLE || m_st[s] == S_PAUSE);
    leave = m_lock && !prog;
    for (int c = 0; c < N_CH; c++) begin
      e_fin[c] = 1'b0;
      mine = m_lock && (c == m_lock_ch);
      case (m_st[c])
        S_IDLE, S_PAUSE: begin
          if (enter && c == s) begin
            m_st[c] = S_PROG; m_cur[c] = 0;
          end else if (ep && !prog && c == s && (m_h[c] + m_m[c] + m_s[c]) != 0) begin
            m_st[c] = S_RUN;
          end
        end
        S_PROG: begin
          if (leave && mine) begin
            m_st[c] = S_IDLE; p_h[c] = m_h[c]; p_m[c] = m_m[c]; p_s[c] = m_s[c];
          end else if (mine) begin
            if (eu != ed) begin
              if (m_cur[c] == 2) begin
                if (eu) m_h[c] = (m_h[c] == HOUR_MAX) ? 0 : m_h[c] + 1;
                else    m_h[c] = (m_h[c] == 0) ? HOUR_MAX : m_h[c] - 1;
              end else begin
                f = (m_cur[c] == 0) ? m_s[c] : m_m[c];
                f = eu ? (f + 1) % 60 : (f + 59) % 60;
                if (m_cur[c] == 0) m_s[c] = f; else m_m[c] = f;
              end
            end
            if (el != er) m_cur[c] = el ? (m_cur[c] + 1) % 3 : (m_cur[c] + 2) % 3;
          end
        end
        S_RUN: begin
          if (ep && !prog && c == s) begin
            m_st[c] = S_PAUSE;
          end else if (tick) begin
            t = m_h[c] * 3600 + m_m[c] * 60 + m_s[c] - 1;
            m_h[c] = t / 3600; m_m[c] = (t / 60) % 60; m_s[c] = t % 60;
            if (t == 0) begin
              m_st[c] = S_RING; e_fin[c] = 1'b1; m_ticks_in_ring[c] = 0;
            end
          end
        end
        default: begin
          if (ep && !prog && c == s) begin
            m_st[c] = S_IDLE; m_h[c] = p_h[c]; m_m[c] = p_m[c]; m_s[c] = p_s[c];
          end else if (tick) begin
            m_ticks_in_ring[c]++;
            if (m_ticks_in_ring[c] == RING_SEC) begin
              m_st[c] = S_IDLE; m_h[c] = p_h[c]; m_m[c] = p_m[c]; m_s[c] = p_s[c];
            end
          end
        end
      endcase
      e_act[c]  = (m_st[c] == S_RUN);
      e_ring[c] = (m_st[c] == S_RING);
    end
    if (enter) begin
      m_lock = 1; m_lock_ch = s;
    end else if (!prog) begin
      m_lock = 0;
    end
    {q_push, q_up, q_dn, q_lf, q_rt} = {push, up, dn, lf, rt};
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // 0 push, 1 arriba, 2 abajo, 3 izquierda, 4 derecha
  task automatic press(input int b);
    case (b)
      0: push = 1'b1;
      1: up   = 1'b1;
      2: dn   = 1'b1;
      3: lf   = 1'b1;
      default: rt = 1'b1;
    endcase
    cycle();
    {push, up, dn, lf, rt} = '0;
    cycle();
  endtask

  task automatic tick_pulse();
    tick = 1'b1; cycle(); tick = 1'b0; cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1; up = 1'b1; push = 1'b1;
    repeat (3) cycle();
    n_tests++;
    if ({act_o, ring_o, fin_o} !== '0) begin
      n_fail++; $display("FAIL reset_flags got %b want 0", {act_o, ring_o, fin_o});
    end
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h0) begin
      n_fail++; $display("FAIL reset_display got %h want 000000", {hh_o, mm_o, ss_o});
    end
    up = 1'b0; push = 1'b0; rst = 1'b0;
    cycle();
    n_tests++;
    if ({act_o, ring_o, fin_o, hh_o, mm_o, ss_o} !== '0) begin
      n_fail++; $display("FAIL post_reset got %h want 0", {act_o, ring_o, fin_o, hh_o, mm_o, ss_o});
    end
  endtask

  task automatic test_program();
    sel = 1'b0; prog = 1'b1; cycle();
    repeat (5) press(1);
    prog = 1'b0; cycle(); cycle();
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h000005) begin
      n_fail++; $display("FAIL program5 got %h want 000005", {hh_o, mm_o, ss_o});
    end
  endtask

  task automatic test_expire();
    int fin_seen;
    logic ring_held;
    sel = 1'b0; prog = 1'b1; cycle();
    repeat (3) press(2);
    prog = 1'b0; cycle();
    press(0);
    n_tests++;
    if (act_o[0] !== 1'b1) begin
      n_fail++; $display("FAIL expire_run got %b want 1", act_o[0]);
    end
    tick_pulse();
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h000001) begin
      n_fail++; $display("FAIL expire_1s got %h want 000001", {hh_o, mm_o, ss_o});
    end
    tick = 1'b1; cycle(); tick = 1'b0;
    n_tests++;
    if ({act_o[0], ring_o[0], fin_o[0]} !== 3'b011) begin
      n_fail++; $display("FAIL expire_enter_ring act/ring/fin got %b want 011", {act_o[0], ring_o[0], fin_o[0]});
    end
    cycle();
    fin_seen = 0; ring_held = 1'b1;
    fin_seen += int'(fin_o[0]);
    for (int k = 0; k < RING_SEC - 1; k++) begin
      tick = 1'b1; cycle(); fin_seen += int'(fin_o[0]); ring_held &= ring_o[0];
      tick = 1'b0; cycle(); fin_seen += int'(fin_o[0]); ring_held &= ring_o[0];
    end
    n_tests++;
    if (fin_seen !== 0 || ring_held !== 1'b1) begin
      n_fail++; $display("FAIL expire_ring_hold fin_extra=%0d ring=%b want 0/1", fin_seen, ring_held);
    end
    tick_pulse();
    n_tests++;
    if (ring_o[0] !== 1'b0 || {hh_o, mm_o, ss_o} !== 24'h000002) begin
      n_fail++; $display("FAIL expire_reload ring=%b val=%h want 0/000002", ring_o[0], {hh_o, mm_o, ss_o});
    end
  endtask

  task automatic test_pause();
    sel = 1'b1; prog = 1'b1; cycle();
    press(3); press(3); press(1);
    prog = 1'b0; cycle();
    press(0);
    tick_pulse();
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h005959) begin
      n_fail++; $display("FAIL pause_borrow got %h want 005959", {hh_o, mm_o, ss_o});
    end
    press(0);
    n_tests++;
    if (act_o[1] !== 1'b0) begin
      n_fail++; $display("FAIL pause_inactive got %b want 0", act_o[1]);
    end
    repeat (3) tick_pulse();
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h005959) begin
      n_fail++; $display("FAIL pause_hold got %h want 005959", {hh_o, mm_o, ss_o});
    end
  endtask

  task automatic test_concurrent();
    sel = 1'b0; press(0);
    sel = 1'b1; prog = 1'b1; cycle();
    tick_pulse();
    sel = 1'b0; press(1);
    tick_pulse();
    n_tests++;
    if ({act_o[0], ring_o[0]} !== 2'b01) begin
      n_fail++; $display("FAIL conc_ch0_ring act/ring got %b want 01", {act_o[0], ring_o[0]});
    end
    prog = 1'b0; cycle();
    press(0);
    n_tests++;
    if (ring_o[0] !== 1'b0 || {hh_o, mm_o, ss_o} !== 24'h000002) begin
      n_fail++; $display("FAIL conc_silence ring=%b val=%h want 0/000002", ring_o[0], {hh_o, mm_o, ss_o});
    end
    sel = 1'b1; cycle(); cycle();
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h005900) begin
      n_fail++; $display("FAIL conc_lock_route got %h want 005900", {hh_o, mm_o, ss_o});
    end
  endtask

  task automatic test_prog_edges();
    sel = 1'b0; prog = 1'b1; cycle();
    press(2); press(2); press(2);
    n_tests++;
    if (ss_o !== 8'h59) begin
      n_fail++; $display("FAIL edge_sec_wrap got %h want 59", ss_o);
    end
    press(3); press(3); press(2);
    n_tests++;
    if (hh_o !== 8'h23) begin
      n_fail++; $display("FAIL edge_hour_wrap got %h want 23", hh_o);
    end
    up = 1'b1; dn = 1'b1; cycle(); up = 1'b0; dn = 1'b0; cycle();
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h230059) begin
      n_fail++; $display("FAIL edge_up_down got %h want 230059", {hh_o, mm_o, ss_o});
    end
    lf = 1'b1; rt = 1'b1; cycle(); lf = 1'b0; rt = 1'b0; cycle();
    press(1);
    n_tests++;
    if ({hh_o, mm_o, ss_o} !== 24'h000059) begin
      n_fail++; $display("FAIL edge_left_right got %h want 000059", {hh_o, mm_o, ss_o});
    end
    prog = 1'b0; cycle();
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    sel = 1'b0; prog = 1'b1; cycle();
    repeat (3) press(1);
    prog = 1'b0; cycle();
    press(0);
    n_tests++;
    if (act_o[0] !== 1'b1 || ss_o !== 8'h03) begin
      n_fail++; $display("FAIL midrun_setup act=%b val=%h want 1/03", act_o[0], ss_o);
    end
    rst = 1'b1; cycle();
    n_tests++;
    if ({act_o, ring_o, fin_o, hh_o, mm_o, ss_o} !== '0) begin
      n_fail++; $display("FAIL midrun_reset got %h want 0", {act_o, ring_o, fin_o, hh_o, mm_o, ss_o});
    end
    rst = 1'b0; cycle();
    press(0);
    n_tests++;
    if (act_o !== '0) begin
      n_fail++; $display("FAIL midrun_zero_start got %b want 0", act_o);
    end
  endtask

  task automatic test_random();
    logic [3*N_CH+23:0] got, exp;
    int shown;
    shown = 0;
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 499) == 0);
      tick = ($urandom_range(0, 3) == 0);
      push = ($urandom_range(0, 5) == 0);
      up   = ($urandom_range(0, 3) == 0);
      dn   = ($urandom_range(0, 5) == 0);
      lf   = ($urandom_range(0, 7) == 0);
      rt   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) prog = ~prog;
      if ($urandom_range(0, 9) == 0) sel = 1'($urandom_range(0, N_CH - 1));
      cycle();
      got = {act_o, ring_o, fin_o, hh_o, mm_o, ss_o};
      exp = {e_act, e_ring, e_fin, bcd(e_h), bcd(e_m), bcd(e_s)};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        if (shown < 10) $display("FAIL random cyc %0d got %h want %h", i, got, exp);
        shown++;
      end
    end
    {rst, tick, push, up, dn, lf, rt, prog} = '0;
    cycle();
  endtask

  initial begin
    {rst, tick, prog, push, up, dn, lf, rt} = '0;
    sel = 1'b0;
    test_reset();
    test_program();
    test_expire();
    test_pause();
    test_concurrent();
    test_prog_edges();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crono_multicanal.md
CRONO_MULTICANAL -- requirements
Module: crono_multicanal

Interface
REQ-001 Parameter N_CH, default 2, number of independent countdown channels (1..8).
REQ-002 Parameter HOUR_MAX, default 23, maximum programmable hours value (BCD, <=99).
REQ-003 Parameter RING_SEC, default 10, Ring duration in tick_1s pulses after expiry.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 tick_1s  in  1  one-clk pulse per second.
REQ-007 ProgramarCrono  in  1  level; program mode request for the selected channel.
REQ-008 PushInicioCrono  in  1  start/pause/silence button; rising edge acts.
REQ-009 arriba, abajo, izquierda, derecha  in  1 each  edit buttons; rising edge acts.
REQ-010 canal_sel  in  $clog2(N_CH) (min 1)  channel addressed by buttons and display.
REQ-011 horasSal, minutosSal, segundosSal  out  8 each  BCD value of the selected channel.
REQ-012 CronoActivo  out  N_CH  bit i high while channel i is in RUN.
REQ-013 Ring  out  N_CH  bit i high while channel i is in RING.
REQ-014 FinalizoCrono  out  N_CH  one-clk pulse when channel i reaches 00:00:00.

Function
REQ-015 Each channel SHALL hold states IDLE, PROG, RUN, PAUSE, RING, plus a BCD value and a BCD preset.
REQ-016 Button edges SHALL be detected as in=1 and previous-sample=0; the resulting register update is visible one clk after the edge cycle.
REQ-017 ProgramarCrono high SHALL move the selected channel from IDLE/PAUSE to PROG; from RUN/RING it is ignored.
REQ-018 The channel entering PROG SHALL be latched; canal_sel changes are ignored for button routing until ProgramarCrono falls.
REQ-019 In PROG, cursor SHALL start at seconds; izquierda moves seconds->minutes->hours->seconds, derecha moves the reverse.
REQ-020 In PROG, arriba SHALL increment the cursor field in BCD (59->00, HOUR_MAX->00); abajo decrements (00->59, 00->HOUR_MAX); no borrow or carry into other fields.
REQ-021 Simultaneous arriba and abajo edges SHALL change nothing; simultaneous izquierda and derecha SHALL leave the cursor unchanged.
REQ-022 ProgramarCrono falling SHALL copy value into preset and return the channel to IDLE.
REQ-023 PushInicioCrono edge with ProgramarCrono low: selected IDLE/PAUSE with non-zero value -> RUN; RUN -> PAUSE; RING -> IDLE (silence); IDLE with zero value -> no change.
REQ-024 PushInicioCrono edge while ProgramarCrono is high SHALL be ignored.
REQ-025 In RUN, each tick_1s SHALL decrement value by one second with BCD borrow (01:00:00 -> 00:59:59); PAUSE holds value.
REQ-026 The tick taking value to 00:00:00 SHALL enter RING and pulse FinalizoCrono for exactly one clk in that same update.
REQ-027 RING SHALL last RING_SEC ticks, then enter IDLE with value reloaded from preset; silence also reloads preset.
REQ-028 All channels SHALL run concurrently from the shared tick_1s regardless of canal_sel.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Reset SHALL force every channel to IDLE, value and preset 00:00:00, cursor seconds, ring counter 0, edge-detect history 0.
REQ-031 During and after reset, CronoActivo, Ring, FinalizoCrono SHALL be 0 and display outputs 8'h00; Reset mid-RUN or mid-RING takes effect at the next edge.

Structure
REQ-032 Package crono_pkg SHALL hold the channel-state enum, cursor encoding, and BCD constants (8'h59, 8'h00).
REQ-033 Sub-module crono_canal SHALL implement one channel (FSM, BCD counter, ring counter), instantiated N_CH times; the top holds edge detection, routing, and output mux.

Verification
REQ-034 Reset, ProgramarCrono=1 on ch0, 5 arriba edges, ProgramarCrono=0 -> display 00:00:05, preset 00:00:05.
REQ-035 Program ch0 to 00:00:02, Push, 2 ticks -> CronoActivo[0] high then low, FinalizoCrono[0] single pulse, Ring[0] high for 10 ticks, then value 00:00:02.
REQ-036 Program ch1 to 01:00:00, run, 1 tick -> 00:59:59; Push -> PAUSE, further ticks hold 00:59:59.
REQ-037 In PROG, abajo at seconds 00 -> 59; izquierda twice, abajo -> hours 23; arriba and abajo in the same cycle -> unchanged.
REQ-038 ch0 RUN while ch1 programmed via canal_sel=1 -> ch0 keeps decrementing; Push during RING silences and reloads preset.
REQ-039 Assert Reset during RUN with value 00:00:03 -> next clk all outputs zero, state IDLE.
